// File: rtl/blit_inhibit_pkg.sv
// Shared definitions for the blitter write-inhibit block:
// B_CMD field positions, pixel size codes and the command bundle.
package blit_inhibit_pkg;

    localparam int unsigned B_ZMODE_LSB = 18;
    localparam int unsigned B_CMPDST    = 25;
    localparam int unsigned B_BCOMPEN   = 26;
    localparam int unsigned B_DCOMPEN   = 27;

    localparam logic [2:0] PIX_8BPP  = 3'd3;
    localparam logic [2:0] PIX_16BPP = 3'd4;
    localparam logic [2:0] PIX_32BPP = 3'd5;

    typedef enum logic [1:0] {
        GRAN_8,
        GRAN_16,
        GRAN_32
    } gran_e;

    typedef struct packed {
        logic       dcompen;
        logic       bcompen;
        logic       cmpdst;
        logic [2:0] zmode;
    } bcmd_t;

    function automatic bcmd_t bcmd_decode(input logic [31:0] din);
        bcmd_t c;
        c.dcompen = din[B_DCOMPEN];
        c.bcompen = din[B_BCOMPEN];
        c.cmpdst  = din[B_CMPDST];
        c.zmode   = din[B_ZMODE_LSB +: 3];
        return c;
    endfunction

endpackage

// File: rtl/blit_lane_cmp.sv
// 64-bit lane compare at 8/16/32-bit granularity, pure combinational.
// hit_b is per byte: every byte of a lane carries that lane's result.
module blit_lane_cmp
    import blit_inhibit_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  gran_e       gran,
    input  logic        op_lt,
    output logic [7:0]  hit_b
);

    logic [7:0] eq8;
    logic [7:0] lt8;
    logic [3:0] eq16;
    logic [3:0] lt16;
    logic [1:0] eq32;
    logic [1:0] lt32;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            eq8[i] = a[8*i +: 8] == b[8*i +: 8];
            lt8[i] = a[8*i +: 8] <  b[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            eq16[i] = a[16*i +: 16] == b[16*i +: 16];
            lt16[i] = a[16*i +: 16] <  b[16*i +: 16];
        end
        for (int i = 0; i < 2; i++) begin
            eq32[i] = a[32*i +: 32] == b[32*i +: 32];
            lt32[i] = a[32*i +: 32] <  b[32*i +: 32];
        end
    end

    always_comb begin
        hit_b = '0;
        unique case (gran)
            GRAN_8: begin
                for (int i = 0; i < 8; i++)
                    hit_b[i] = op_lt ? lt8[i] : eq8[i];
            end
            GRAN_16: begin
                for (int i = 0; i < 8; i++)
                    hit_b[i] = op_lt ? lt16[i/2] : eq16[i/2];
            end
            GRAN_32: begin
                for (int i = 0; i < 8; i++)
                    hit_b[i] = op_lt ? lt32[i/4] : eq32[i/4];
            end
            default: hit_b = '0;
        endcase
    end

endmodule

// File: rtl/blit_inhibit.sv
// Blitter write-inhibit generator: data/Z/bit compares produce byte
// write enables, a registered nowrite flag and a saturating inhibit count.
module blit_inhibit
    import blit_inhibit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             xreset_n,
    input  logic             cmd_ld,
    input  logic [31:0]      gpu_din,
    input  logic [2:0]       pixsize,
    input  logic             data_valid,
    input  logic [63:0]      srcd,
    input  logic [63:0]      dstd,
    input  logic [63:0]      patd,
    input  logic [63:0]      srcz,
    input  logic [63:0]      dstz,
    input  logic [7:0]       cbits,
    input  logic [7:0]       emask,
    input  logic             dwrite_1,
    input  logic             stopped,
    output logic [7:0]       dstwe,
    output logic [3:0]       zwe,
    output logic             nowrite,
    output logic [CNT_W-1:0] inhibit_cnt
);

    bcmd_t            cmd_q, cmd_d;
    logic [7:0]       dstwe_q, dstwe_d;
    logic [3:0]       zwe_q, zwe_d;
    logic             nowrite_q, nowrite_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        is8, is16, is32, sub_byte;
    gran_e       gran;
    logic [63:0] cmpv;
    logic [7:0]  d_eq_b, z_eq_b, z_lt_b;
    logic [7:0]  cb_b, d_inh_b, b_inh_b, z_inh_b, inh_b;
    logic        upd;
    logic        unused_din;

    assign unused_din = ^{gpu_din[31:28], gpu_din[24:21], gpu_din[17:0]};

    always_comb begin
        is8      = pixsize == PIX_8BPP;
        is16     = pixsize == PIX_16BPP;
        is32     = pixsize == PIX_32BPP;
        sub_byte = ~(is8 | is16 | is32);
        gran     = is16 ? GRAN_16 : (is32 ? GRAN_32 : GRAN_8);
        cmpv     = cmd_q.cmpdst ? dstd : srcd;
    end

    blit_lane_cmp u_dcmp (
        .a     (cmpv),
        .b     (patd),
        .gran  (gran),
        .op_lt (1'b0),
        .hit_b (d_eq_b)
    );

    blit_lane_cmp u_zeq (
        .a     (srcz),
        .b     (dstz),
        .gran  (GRAN_16),
        .op_lt (1'b0),
        .hit_b (z_eq_b)
    );

    blit_lane_cmp u_zlt (
        .a     (srcz),
        .b     (dstz),
        .gran  (GRAN_16),
        .op_lt (1'b1),
        .hit_b (z_lt_b)
    );

    // Inhibits are spread to bytes so every mode shares one enable path.
    always_comb begin
        for (int j = 0; j < 8; j++)
            cb_b[j] = is16 ? cbits[j/2] : (is32 ? cbits[j/4] : cbits[j]);
        d_inh_b = (cmd_q.dcompen & ~sub_byte) ? d_eq_b : 8'h00;
        b_inh_b = {8{cmd_q.bcompen}} & ~cb_b;
        z_inh_b = ({8{cmd_q.zmode[0]}} & z_lt_b)
                | ({8{cmd_q.zmode[1]}} & z_eq_b)
                | ({8{cmd_q.zmode[2]}} & ~z_lt_b & ~z_eq_b);
        if (!is16)
            z_inh_b = 8'h00;
        inh_b = d_inh_b | b_inh_b | z_inh_b;
    end

    always_comb begin
        upd       = data_valid & ~stopped;
        dstwe_d   = dstwe_q;
        zwe_d     = zwe_q;
        nowrite_d = nowrite_q;
        if (upd) begin
            dstwe_d = emask & ~inh_b;
            for (int i = 0; i < 4; i++)
                zwe_d[i] = is16 & ~inh_b[2*i];
            nowrite_d = (|emask) & ~(|(emask & ~inh_b));
        end
    end

    always_comb begin
        cmd_d = cmd_ld ? bcmd_decode(gpu_din) : cmd_q;
        cnt_d = cnt_q;
        if (cmd_ld)
            cnt_d = '0;
        else if (dwrite_1 & nowrite_q & ~stopped & ~(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (!xreset_n) begin
            cmd_q     <= '0;
            dstwe_q   <= '0;
            zwe_q     <= '0;
            nowrite_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cmd_q     <= cmd_d;
            dstwe_q   <= dstwe_d;
            zwe_q     <= zwe_d;
            nowrite_q <= nowrite_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dstwe       = dstwe_q;
    assign zwe         = zwe_q;
    assign nowrite     = nowrite_q;
    assign inhibit_cnt = cnt_q;

endmodule

// File: tb/tb_blit_inhibit.sv
// Directed and randomized bench for blit_inhibit against a
// per-pixel reference model of the inhibit rules.
module tb_blit_inhibit;

    logic        sys_clk = 1'b0;
    logic        xreset_n;
    logic        cmd_ld;
    logic [31:0] gpu_din;
    logic [2:0]  pixsize;
    logic        data_valid;
    logic [63:0] srcd, dstd, patd, srcz, dstz;
    logic [7:0]  cbits, emask;
    logic        dwrite_1, stopped;
    logic [7:0]  dstwe;
    logic [3:0]  zwe;
    logic        nowrite;
    logic [15:0] inhibit_cnt;

    always #5 sys_clk = ~sys_clk;

    blit_inhibit #(.CNT_W(16)) dut (
        .sys_clk     (sys_clk),
        .xreset_n    (xreset_n),
        .cmd_ld      (cmd_ld),
        .gpu_din     (gpu_din),
        .pixsize     (pixsize),
        .data_valid  (data_valid),
        .srcd        (srcd),
        .dstd        (dstd),
        .patd        (patd),
        .srcz        (srcz),
        .dstz        (dstz),
        .cbits       (cbits),
        .emask       (emask),
        .dwrite_1    (dwrite_1),
        .stopped     (stopped),
        .dstwe       (dstwe),
        .zwe         (zwe),
        .nowrite     (nowrite),
        .inhibit_cnt (inhibit_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic       m_dc, m_bc, m_cd;
    logic [2:0] m_zm;
    logic [7:0] m_we;
    logic [3:0] m_zwe;
    logic       m_nw;
    int         m_cnt;

    // Walk the phrase pixel by pixel and apply the inhibit rules directly.
    function automatic void ref_phrase(output logic [7:0] we,
                                       output logic [3:0] zw,
                                       output logic nw);
        int              w;
        logic [7:0]      inh;
        logic [63:0]     cv;
        longint unsigned msk, a, pp, zs, zd;
        bit              pi;
        w   = (pixsize == 3) ? 8 : (pixsize == 4) ? 16 : (pixsize == 5) ? 32 : 0;
        inh = 8'h00;
        zw  = 4'h0;
        cv  = m_cd ? dstd : srcd;
        if (w == 0) begin
            for (int j = 0; j < 8; j++)
                inh[j] = m_bc && !cbits[j];
        end else begin
            msk = (64'd1 << w) - 64'd1;
            for (int p = 0; p < 64 / w; p++) begin
                a  = (cv >> (p * w)) & msk;
                pp = (patd >> (p * w)) & msk;
                pi = (m_dc && a == pp) || (m_bc && !cbits[p]);
                if (w == 16) begin
                    zs = (srcz >> (p * 16)) & 64'hFFFF;
                    zd = (dstz >> (p * 16)) & 64'hFFFF;
                    pi = pi || (m_zm[0] && zs < zd) || (m_zm[1] && zs == zd)
                            || (m_zm[2] && zs > zd);
                    zw[p] = !pi;
                end
                for (int k = 0; k < w / 8; k++)
                    inh[p * (w / 8) + k] = pi;
            end
        end
        we = emask & ~inh;
        nw = (emask != 8'h00) && (we == 8'h00);
    endfunction

    task automatic tick();
        logic [7:0] we;
        logic [3:0] zw;
        logic       nw;
        if (!xreset_n) begin
            {m_dc, m_bc, m_cd, m_zm} = '0;
            m_we = 8'h00; m_zwe = 4'h0; m_nw = 1'b0; m_cnt = 0;
        end else begin
            ref_phrase(we, zw, nw);
            if (cmd_ld)
                m_cnt = 0;
            else if (dwrite_1 && m_nw && !stopped && m_cnt < 65535)
                m_cnt++;
            if (data_valid && !stopped) begin
                m_we = we; m_zwe = zw; m_nw = nw;
            end
            if (cmd_ld) begin
                m_dc = gpu_din[27]; m_bc = gpu_din[26];
                m_cd = gpu_din[25]; m_zm = gpu_din[20:18];
            end
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dstwe"}, 32'(dstwe), 32'(m_we));
        chk({tag, ".zwe"}, 32'(zwe), 32'(m_zwe));
        chk({tag, ".nowrite"}, 32'(nowrite), 32'(m_nw));
        chk({tag, ".cnt"}, 32'(inhibit_cnt), 32'(m_cnt));
    endtask

    task automatic load_cmd(input logic dc, input logic bc,
                            input logic cd, input logic [2:0] zm);
        gpu_din = 32'h0;
        gpu_din[27] = dc; gpu_din[26] = bc;
        gpu_din[25] = cd; gpu_din[20:18] = zm;
        cmd_ld = 1'b1;
        tick();
        cmd_ld = 1'b0;
    endtask

    task automatic phrase();
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] flip;
        xreset_n = 1'b0; cmd_ld = 1'b0; gpu_din = '0; pixsize = 3'd3;
        data_valid = 1'b0; srcd = '0; dstd = '0; patd = '0;
        srcz = '0; dstz = '0; cbits = '0; emask = '0;
        dwrite_1 = 1'b0; stopped = 1'b0;

        tick(); tick();
        check_all("reset");
        chk("reset.dstwe0", 32'(dstwe), 32'h0);
        chk("reset.cnt0", 32'(inhibit_cnt), 32'h0);
        xreset_n = 1'b1;
        tick();

        load_cmd(1'b1, 1'b0, 1'b0, 3'b000);
        pixsize = 3'd3;
        srcd = {$urandom, $urandom};
        patd = srcd ^ 64'h0000_0000_5A00_0000;
        emask = 8'hFF;
        phrase();
        check_all("byte3");
        chk("byte3.dstwe", 32'(dstwe), 32'h08);
        chk("byte3.nowrite", 32'(nowrite), 32'h0);

        patd = srcd;
        phrase();
        chk("alleq.nowrite", 32'(nowrite), 32'h1);
        dwrite_1 = 1'b1;
        tick();
        check_all("cnt1");
        chk("cnt1.cnt", 32'(inhibit_cnt), 32'h1);
        stopped = 1'b1;
        patd = ~srcd;
        data_valid = 1'b1;
        tick(); tick(); tick();
        data_valid = 1'b0;
        check_all("stop");
        chk("stop.cnt", 32'(inhibit_cnt), 32'h1);
        chk("stop.nowrite", 32'(nowrite), 32'h1);
        stopped = 1'b0; dwrite_1 = 1'b0;

        load_cmd(1'b0, 1'b0, 1'b0, 3'b001);
        pixsize = 3'd4;
        srcz = {16'd1, 16'd9, 16'd9, 16'd5};
        dstz = {16'd3, 16'd9, 16'd7, 16'd7};
        emask = 8'hFF;
        phrase();
        check_all("zlt");
        chk("zlt.zwe", 32'(zwe), 32'h6);
        chk("zlt.dstwe", 32'(dstwe), 32'h3C);

        load_cmd(1'b0, 1'b1, 1'b0, 3'b000);
        pixsize = 3'd3; cbits = 8'h00; emask = 8'h00;
        phrase();
        check_all("empty");
        chk("empty.nowrite", 32'(nowrite), 32'h0);
        emask = 8'h0F;
        phrase();
        check_all("bmask");
        chk("bmask.nowrite", 32'(nowrite), 32'h1);

        dwrite_1 = 1'b1;
        repeat (65535) tick();
        check_all("sat");
        chk("sat.cnt", 32'(inhibit_cnt), 32'hFFFF);
        tick();
        chk("sat.hold", 32'(inhibit_cnt), 32'hFFFF);
        load_cmd(1'b0, 1'b1, 1'b0, 3'b000);
        check_all("ldwin");
        chk("ldwin.cnt", 32'(inhibit_cnt), 32'h0);
        tick();
        chk("ldwin.inc", 32'(inhibit_cnt), 32'h1);
        dwrite_1 = 1'b0;

        stopped = 1'b1;
        load_cmd(1'b1, 1'b0, 1'b1, 3'b000);
        stopped = 1'b0;
        pixsize = 3'd5; emask = 8'hFF;
        dstd = {$urandom, $urandom}; patd = dstd; srcd = ~dstd;
        phrase();
        check_all("ldstop");
        chk("ldstop.nowrite", 32'(nowrite), 32'h1);

        for (int it = 0; it < 400; it++) begin
            pixsize = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                  : 3'($urandom_range(3, 5));
            srcd = {$urandom, $urandom};
            dstd = {$urandom, $urandom};
            for (int b = 0; b < 8; b++)
                flip[8*b +: 8] = $urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            patd = (m_cd ? dstd : srcd) ^ flip;
            for (int l = 0; l < 4; l++) begin
                srcz[16*l +: 16] = 16'($urandom_range(0, 3));
                dstz[16*l +: 16] = 16'($urandom_range(0, 3));
            end
            cbits = 8'($urandom);
            emask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            data_valid = 1'($urandom_range(0, 1));
            dwrite_1 = 1'($urandom_range(0, 1));
            stopped = ($urandom_range(0, 7) == 0);
            cmd_ld = ($urandom_range(0, 15) == 0);
            gpu_din = $urandom;
            tick();
            check_all("rnd");
        end
        cmd_ld = 1'b0; stopped = 1'b0;

        load_cmd(1'b1, 1'b1, 1'b0, 3'b111);
        pixsize = 3'd4; emask = 8'hFF; cbits = 8'h00;
        phrase();
        dwrite_1 = 1'b1;
        tick();
        data_valid = 1'b1;
        xreset_n = 1'b0;
        tick();
        check_all("rstmid");
        chk("rstmid.dstwe", 32'(dstwe), 32'h0);
        chk("rstmid.cnt", 32'(inhibit_cnt), 32'h0);
        xreset_n = 1'b1;
        data_valid = 1'b0;
        dwrite_1 = 1'b0;
        tick();
        check_all("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
